// File: rtl/pow_n_pipelined.sv
// pow_n_pipelined: computes n to the power N over an (N-1)-stage pipeline.
// Each stage does one W x W multiply, keeps the base for the next stage and
// carries a sticky overflow flag. The handshake stalls the whole pipeline
// while a finished result waits for the consumer. Bubbles are kept in place,
// so results leave in the same order as operands were accepted.
module pow_n_pipelined #(
  parameter int W = 8,
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_en,
  input  logic         n_vld,
  output logic         n_rdy,
  input  logic [W-1:0] n,
  output logic         res_vld,
  input  logic         res_rdy,
  output logic [W-1:0] res,
  output logic         res_ovf,
  output logic         busy
);

  localparam int S = N - 1;

  // Per-stage state, stage 1 is fed from the input port, stage S drives res.
  logic [S:1]     vld_p;
  logic [S:1]     ovf_p;
  logic [W-1:0]   base_p [1:S];
  logic [W-1:0]   acc_p  [1:S];

  // Full-width products feeding each stage.
  logic [2*W-1:0] prod   [1:S];

  logic stall;
  logic adv;

  // Unsigned W x W multiply that keeps all 2W product bits.
  function automatic logic [2*W-1:0] mul_full(input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic [2*W-1:0] ax;
    logic [2*W-1:0] bx;
    ax = {{W{1'b0}}, a};
    bx = {{W{1'b0}}, b};
    return ax * bx;
  endfunction

  // True when the product does not fit in W bits.
  function automatic logic hi_nz(input logic [2*W-1:0] p);
    return |p[2*W-1:W];
  endfunction

  // The whole pipeline moves only when enabled and the output is not blocked.
  always_comb begin
    stall = res_vld & ~res_rdy;
    adv   = clk_en & ~stall;
    n_rdy = adv & rst_n;
  end

  // Multiplier inputs: stage 1 squares the operand, later stages multiply
  // the running accumulator by the carried base.
  always_comb begin
    prod[1] = mul_full(n, n);
    for (int k = 2; k <= S; k++) begin
      prod[k] = mul_full(acc_p[k-1], base_p[k-1]);
    end
  end

  // Pipeline registers: reset clears everything, otherwise shift on adv.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p <= '0;
      ovf_p <= '0;
      for (int k = 1; k <= S; k++) begin
        base_p[k] <= '0;
        acc_p[k]  <= '0;
      end
    end else if (adv) begin
      // stage 1: square the accepted operand
      vld_p[1]  <= n_vld;
      base_p[1] <= n;
      acc_p[1]  <= prod[1][W-1:0];
      ovf_p[1]  <= hi_nz(prod[1]);
      // stages 2..S: one more factor of base, overflow stays sticky
      for (int k = 2; k <= S; k++) begin
        vld_p[k]  <= vld_p[k-1];
        base_p[k] <= base_p[k-1];
        acc_p[k]  <= prod[k][W-1:0];
        ovf_p[k]  <= ovf_p[k-1] | hi_nz(prod[k]);
      end
    end
  end

  // Result comes straight from the last stage registers.
  always_comb begin
    res_vld = vld_p[S];
    res     = acc_p[S];
    res_ovf = ovf_p[S];
    busy    = |vld_p;
  end

endmodule

// File: tb/tb_pow_n_pipelined.sv
// Bench for pow_n_pipelined: directed handshake/latency cases plus a random
// run on an N=5 and an N=2 instance against a queue-based power model.
module tb_pow_n_pipelined;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;

  logic         ce5, nv5, nr5, rv5, rr5, ro5, b5;
  logic [W-1:0] n5, r5;
  logic         ce2, nv2, nr2, rv2, rr2, ro2, b2;
  logic [W-1:0] n2, r2;

  int errs   = 0;
  int checks = 0;

  longint unsigned q5[$];
  longint unsigned q2[$];

  int exp_r[6] = '{1, 32, 243, 0, 8'h35, 8'h60};
  int exp_o[6] = '{0, 0, 0, 1, 1, 1};

  always #5 clk = ~clk;

  pow_n_pipelined #(.W(W), .N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .clk_en(ce5), .n_vld(nv5), .n_rdy(nr5), .n(n5),
    .res_vld(rv5), .res_rdy(rr5), .res(r5), .res_ovf(ro5), .busy(b5));

  pow_n_pipelined #(.W(W), .N(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clk_en(ce2), .n_vld(nv2), .n_rdy(nr2), .n(n2),
    .res_vld(rv2), .res_rdy(rr2), .res(r2), .res_ovf(ro2), .busy(b2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint unsigned pow_ref(input int unsigned b, input int e);
    longint unsigned v = 1;
    for (int i = 0; i < e; i++) v = v * longint'(b);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for N=5: push on acceptance, pop and compare on consumption.
  logic       stl5 = 1'b0;
  logic [9:0] hold5;
  longint unsigned e5;
  always @(negedge clk) begin
    if (stl5) chk("d5_hold", 64'({r5, ro5, rv5}), 64'(hold5));
    stl5  = rst_n && rv5 && !rr5;
    hold5 = {r5, ro5, rv5};
    if (!rst_n) begin
      q5.delete();
    end else begin
      if (rv5 && rr5 && ce5) begin
        if (q5.size() == 0) chk("d5_spurious", 64'(r5), 64'hFFFF);
        else begin
          e5 = q5.pop_front();
          chk("d5_res", 64'(r5), 64'(e5[W-1:0]));
          chk("d5_ovf", 64'(ro5), 64'(e5 > 255));
        end
      end
      if (nv5 && nr5) q5.push_back(pow_ref(int'(n5), 5));
    end
  end

  // Scoreboard for N=2.
  logic       stl2 = 1'b0;
  logic [9:0] hold2;
  longint unsigned e2;
  always @(negedge clk) begin
    if (stl2) chk("d2_hold", 64'({r2, ro2, rv2}), 64'(hold2));
    stl2  = rst_n && rv2 && !rr2;
    hold2 = {r2, ro2, rv2};
    if (!rst_n) begin
      q2.delete();
    end else begin
      if (rv2 && rr2 && ce2) begin
        if (q2.size() == 0) chk("d2_spurious", 64'(r2), 64'hFFFF);
        else begin
          e2 = q2.pop_front();
          chk("d2_res", 64'(r2), 64'(e2[W-1:0]));
          chk("d2_ovf", 64'(ro2), 64'(e2 > 255));
        end
      end
      if (nv2 && nr2) q2.push_back(pow_ref(int'(n2), 2));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ce5 = 1'b0; nv5 = 1'b0; n5 = '0; rr5 = 1'b1;
    ce2 = 1'b0; nv2 = 1'b0; n2 = '0; rr2 = 1'b1;

    // Reset with clk_en low still clears state.
    step();
    @(negedge clk);
    chk("rst_vld", 64'(rv5), 0);
    chk("rst_res", 64'(r5), 0);
    chk("rst_ovf", 64'(ro5), 0);
    chk("rst_busy", 64'(b5), 0);
    chk("rst_nrdy", 64'(nr5), 0);
    chk("rst_busy2", 64'(b2), 0);
    step();
    ce5 = 1'b1; ce2 = 1'b1;
    @(negedge clk);
    chk("rst_nrdy_ce", 64'(nr5), 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_nrdy", 64'(nr5), 1);

    // 3, 2, 4 back to back, N=5.
    step(); nv5 = 1'b1; n5 = 8'd3;
    step(); n5 = 8'd2;
    step(); n5 = 8'd4;
    step(); nv5 = 1'b0;
    @(negedge clk); chk("b2b_early", 64'(rv5), 0);
    @(negedge clk); chk("b2b_v0", 64'(rv5), 1); chk("b2b_r0", 64'(r5), 243); chk("b2b_o0", 64'(ro5), 0);
    @(negedge clk); chk("b2b_v1", 64'(rv5), 1); chk("b2b_r1", 64'(r5), 32);  chk("b2b_o1", 64'(ro5), 0);
    @(negedge clk); chk("b2b_v2", 64'(rv5), 1); chk("b2b_r2", 64'(r5), 0);   chk("b2b_o2", 64'(ro5), 1);
    @(negedge clk); chk("b2b_end", 64'(rv5), 0);

    // N=2: 15 then 16.
    step(); nv2 = 1'b1; n2 = 8'd15;
    step(); n2 = 8'd16;
    @(negedge clk); chk("sq_v0", 64'(rv2), 1); chk("sq_r0", 64'(r2), 225); chk("sq_o0", 64'(ro2), 0);
    step(); nv2 = 1'b0;
    @(negedge clk); chk("sq_v1", 64'(rv2), 1); chk("sq_r1", 64'(r2), 0); chk("sq_o1", 64'(ro2), 1);
    @(negedge clk); chk("sq_end", 64'(rv2), 0);

    // Stream 1..6 with a 3-cycle output stall.
    step(); rr5 = 1'b0;
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          int  cnt;
          logic a;
          cnt = 0;
          n5 = 8'(i); nv5 = 1'b1;
          do begin
            @(negedge clk); a = nr5;
            step(); cnt++;
          end while (!a && cnt < 40);
          if (!a) chk("strm_accept_to", 64'(cnt), 0);
        end
        nv5 = 1'b0;
      end
      begin
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (!rv5 && cnt < 30) begin @(negedge clk); cnt++; end
        chk("strm_rise_to", 64'(cnt < 30), 1);
        for (int k = 0; k < 3; k++) begin
          chk("strm_nrdy_hold", 64'(nr5), 0);
          chk("strm_res_hold", 64'(r5), 1);
          chk("strm_vld_hold", 64'(rv5), 1);
          step();
          if (k < 2) @(negedge clk);
        end
        rr5 = 1'b1;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          chk("strm_vld", 64'(rv5), 1);
          chk("strm_res", 64'(r5), 64'(exp_r[i]));
          chk("strm_ovf", 64'(ro5), 64'(exp_o[i]));
        end
        @(negedge clk); chk("strm_end", 64'(rv5), 0);
      end
    join

    // clk_en drop for 2 cycles mid-flight.
    step(); nv5 = 1'b1; n5 = 8'd3;
    step(); nv5 = 1'b0;
    step(); ce5 = 1'b0;
    @(negedge clk); chk("ce_nrdy0", 64'(nr5), 0);
    step();
    @(negedge clk); chk("ce_nrdy1", 64'(nr5), 0);
    step(); ce5 = 1'b1;
    @(negedge clk); chk("ce_v3", 64'(rv5), 0);
    @(negedge clk); chk("ce_v4", 64'(rv5), 0);
    @(negedge clk); chk("ce_v5", 64'(rv5), 1); chk("ce_r5", 64'(r5), 243);
    @(negedge clk); chk("ce_end", 64'(rv5), 0);

    // Reset mid-flight discards the in-flight 3.
    step(); nv5 = 1'b1; n5 = 8'd3;
    step(); nv5 = 1'b0;
    step(); rst_n = 1'b0;
    @(negedge clk); chk("mr_nrdy", 64'(nr5), 0);
    step(); rst_n = 1'b1; nv5 = 1'b1; n5 = 8'd2;
    @(negedge clk);
    chk("mr_busy", 64'(b5), 0); chk("mr_vld", 64'(rv5), 0);
    chk("mr_res", 64'(r5), 0);  chk("mr_ovf", 64'(ro5), 0);
    chk("mr_nrdy1", 64'(nr5), 1);
    step(); nv5 = 1'b0;
    @(negedge clk); chk("mr_v3", 64'(rv5), 0);
    @(negedge clk); chk("mr_v4", 64'(rv5), 0);
    @(negedge clk); chk("mr_v5", 64'(rv5), 0);
    @(negedge clk); chk("mr_v6", 64'(rv5), 1); chk("mr_r6", 64'(r5), 32); chk("mr_o6", 64'(ro5), 0);
    @(negedge clk); chk("mr_end", 64'(rv5), 0);

    // Random traffic on both instances.
    for (int c = 0; c < 3000; c++) begin
      step();
      ce5 = ($urandom_range(0, 9) != 0);
      nv5 = ($urandom_range(0, 2) != 0);
      rr5 = ($urandom_range(0, 3) != 0);
      n5  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom);
      ce2 = ($urandom_range(0, 9) != 0);
      nv2 = ($urandom_range(0, 2) != 0);
      rr2 = ($urandom_range(0, 3) != 0);
      n2  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom);
    end
    step();
    nv5 = 1'b0; rr5 = 1'b1; ce5 = 1'b1;
    nv2 = 1'b0; rr2 = 1'b1; ce2 = 1'b1;
    repeat (10) step();
    @(negedge clk);
    chk("drain_busy5", 64'(b5), 0);
    chk("drain_busy2", 64'(b2), 0);
    chk("drain_q5", 64'(q5.size()), 0);
    chk("drain_q2", 64'(q2.size()), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pow_n_pipelined.md
POW_N_PIPELINED -- requirements
Module: pow_n_pipelined

Interface
REQ-001 The block SHALL have parameter W, default 8, which sets the operand and result width in bits (W >= 2).
REQ-002 The block SHALL have parameter N, default 5, which sets the exponent (N >= 2).
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port clk_en, input, 1 bit: clock enable; when low, all state holds.
REQ-006 Port n_vld, input, 1 bit: the operand on n is valid.
REQ-007 Port n_rdy, output, 1 bit: the block can accept an operand this cycle.
REQ-008 Port n, input, W bits: unsigned operand.
REQ-009 Port res_vld, output, 1 bit: the result on res is valid.
REQ-010 Port res_rdy, input, 1 bit: the downstream consumer accepts the result.
REQ-011 Port res, output, W bits: low W bits of n to the power N.
REQ-012 Port res_ovf, output, 1 bit: the true value of n to the power N does not fit in W bits.
REQ-013 Port busy, output, 1 bit: at least one pipeline stage holds a valid operand.

Function
REQ-014 The pipeline SHALL have N-1 stages, S1..S(N-1); each stage holds a valid bit, a base (W bits), an accumulator (W bits) and a sticky overflow bit.
REQ-015 Define stall = res_vld & ~res_rdy and adv = clk_en & ~stall.
REQ-016 n_rdy SHALL equal adv & rst_n (combinational).
REQ-017 An operand is accepted on a rising edge where n_vld & n_rdy; n_vld while n_rdy is low SHALL be ignored, with no latching.
REQ-018 On an edge where adv = 1, S1 SHALL load: valid = n_vld, base = n, acc = low W bits of n*n, ovf = upper W bits of the 2W-bit product are nonzero.
REQ-019 On an edge where adv = 1, each Sk with k > 1 SHALL load from S(k-1): valid, base, acc = low W bits of acc*base, ovf = previous ovf OR upper W bits of the product are nonzero.
REQ-020 When adv = 0, all stages SHALL hold their contents, including valid bits.
REQ-021 Bubbles SHALL advance with the pipeline and SHALL NOT be collapsed; result order SHALL equal acceptance order.
REQ-022 res, res_ovf and res_vld SHALL be driven directly from the S(N-1) registers.
REQ-023 Latency, with no stall and clk_en held high, SHALL be N-1 rising edges: acceptance at edge E0 gives res_vld high after edge E(N-2).
REQ-024 Throughput SHALL be one operand per cycle when there is no stall and clk_en is high.
REQ-025 A result is consumed on an edge where res_vld & res_rdy & clk_en; on that same edge a new operand MAY be accepted, with no lost or duplicated results.
REQ-026 While res_vld & ~res_rdy, res and res_ovf SHALL remain stable until consumed.
REQ-027 busy SHALL be the OR of all stage valid bits.
REQ-028 Arithmetic SHALL be unsigned, mod 2^W; the 0 and 1 operands SHALL give res = 0 and res = 1 respectively, each with res_ovf = 0.

Reset
REQ-029 On any edge where rst_n = 0, regardless of clk_en, all stage valid bits, sticky overflow bits, accumulators and bases SHALL clear to 0.
REQ-030 While rst_n = 0, the outputs SHALL read res_vld = 0, res = 0, res_ovf = 0, busy = 0 and n_rdy = 0.
REQ-031 A reset asserted mid-operation SHALL discard all in-flight operands; no result for them SHALL appear after reset is released.
REQ-032 In the first cycle after rst_n returns high, n_rdy SHALL equal clk_en.

Verification
REQ-033 With W=8 and N=5, the bench SHALL send 3, 2 and 4 back-to-back with res_rdy = 1 -> results 243/ovf 0, 32/ovf 0 and 0/ovf 1 on three consecutive cycles, the first appearing after edge E3.
REQ-034 With W=8 and N=2, the bench SHALL send 15 then 16 -> results 225/ovf 0 then 0/ovf 1, each appearing one edge after acceptance.
REQ-035 With W=8 and N=5, the bench SHALL stream 1..6 while holding res_rdy = 0 for 3 cycles once res_vld rises -> n_rdy = 0 during the hold, res held at 1, then results 1, 32, 243, 0 (ovf 1), 0x35 (ovf 1), 0x60 (ovf 1) in order, with no gaps and no duplicates.
REQ-036 With W=8 and N=5, the bench SHALL send 3 and drop clk_en for 2 cycles mid-flight -> result 243 arrives exactly 2 cycles late, and n_rdy = 0 while clk_en = 0.
REQ-037 With W=8 and N=5, the bench SHALL send 3, pull rst_n low for 1 cycle two edges later, then send 2 -> no 243 ever appears, 32 appears 4 edges after acceptance, and busy = 0 in the cycle after reset.
REQ-038 The bench SHALL run randomized n_vld, res_rdy and clk_en against a reference model of n to the power N -> every result matches in value, order and ovf, and busy = 0 after drain.
